uart_frame_writer: RTL and testbench
====================================

# uart_frame_writer

Downstream stage of the UART receiver: accepts received bytes as single-cycle strobes, recognises framed packets (sync, length, payload, checksum), and writes each payload byte into the command memory through a registered write port. Validated frames are committed with a one-cycle `frame_done` pulse. Malformed or stalled frames raise `frame_err` with a cause code. The block sits between the receiver and the 113-entry command memory read by the pulse/control logic.

## Interface
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `BASE_ADDR`, 113: memory address of the first payload byte; addresses descend from here.
- `MAX_LEN`, 113: largest legal payload length. Must be ≤ `BASE_ADDR`.
- `TIMEOUT_CYCLES`, 100000: inter-byte timeout in `clk_Rx` cycles (1 ms at 100 MHz).
- `clk_Rx` in, 1: system clock; all logic on its rising edge.
- `reset` in, 1: synchronous, active-high reset; clock `clk_Rx`.
- `rx_data` in, 8: received byte; valid only while `rx_valid` = 1.
- `rx_valid` in, 1: one-cycle strobe per received byte.
- `mem_wr_en` out, 1: memory write enable, one cycle per payload byte.
- `mem_wr_addr` out, 8: memory write address.
- `mem_wr_data` out, 8: memory write data.
- `frame_done` out, 1: one-cycle pulse when a frame passes the checksum.
- `frame_len` out, 8: payload length of the last good frame; held until the next good frame.
- `frame_err` out, 1: one-cycle pulse when a frame is aborted.
- `err_code` out, 2: abort cause, held until the next error. 01 = bad length, 10 = checksum, 11 = timeout, 00 = none since reset.
- `busy` out, 1: high in any state other than IDLE.

## Operation
- States: IDLE, LEN, PAYLOAD, CSUM.
- IDLE
  - `rx_valid` with `rx_data` == `SYNC_BYTE` → LEN.
  - Any other byte is discarded silently.
- LEN
  - Byte == 0 or byte > `MAX_LEN` → error 01, return to IDLE.
  - Otherwise latch `len`, set `sum` = byte, set `idx` = 0, go to PAYLOAD.
- PAYLOAD
  - Each byte is written to address `BASE_ADDR - idx`.
  - Update `sum` += byte (mod 256) and `idx` += 1.
  - After byte `idx` == `len`-1 is accepted → CSUM.
- CSUM
  - Byte + `sum` == 8'h00 (mod 256) → `frame_done`, `frame_len` ← `len`.
  - Otherwise → error 10.
  - Both cases return to IDLE.
- Timeout
  - The counter clears on every `rx_valid` and on entry to IDLE.
  - It counts only outside IDLE.
  - Reaching `TIMEOUT_CYCLES`-1 → error 11, return to IDLE.
- Payload bytes written before an abort remain in memory. Consumers treat memory contents as valid only after `frame_done`.
- A sync byte received mid-frame is treated as data; there is no resynchronisation inside a frame.
- Arithmetic
  - `sum` is 8 bits and wraps.
  - `idx` is 8 bits. `MAX_LEN` ≤ `BASE_ADDR` guarantees addresses stay ≥ `BASE_ADDR - MAX_LEN + 1`, with no wrap.

## Timing
- Reset values: `mem_wr_en` = 0, `mem_wr_addr` = 0, `mem_wr_data` = 0, `frame_done` = 0, `frame_len` = 0, `frame_err` = 0, `err_code` = 00, `busy` = 0; state is IDLE; counters and `sum` are 0.
- Reset asserted mid-frame: return to IDLE on that edge; no write and no pulse issued. A write strobe already registered is dropped.
- Write latency: `mem_wr_en`/`mem_wr_addr`/`mem_wr_data` are registered and assert on the cycle after the `rx_valid` cycle.
- `frame_done` and `frame_err` assert on the cycle after the terminating byte or timeout terminal count.
- `frame_len` and `err_code` update on the same edge as their pulses.
- `rx_valid` on the same cycle as timeout terminal count: the byte wins, the counter clears, and no error is raised.
- Back-to-back `rx_valid` on consecutive cycles must be accepted with no byte loss.
- `frame_done` and `frame_err` are mutually exclusive.
- A new sync byte arriving on the cycle after the CSUM byte is accepted, because the state is IDLE by then.

## Structure
- Package `uart_frame_pkg`:
  - State enum.
  - Error code constants `ERR_NONE`/`ERR_LEN`/`ERR_CSUM`/`ERR_TMO`.
  - Default `SYNC_BYTE`.
- Sub-module `uart_frame_timeout`:
  - Parameterised down-counter.
  - Inputs: `clear`, `enable`.
  - Output: one-cycle `expired`.
- FSM, checksum and write port stay in the top module.

## Test plan
- Good frame: reset, then bytes A5 03 10 20 30 9D → writes (113,10) (112,20) (111,30), then `frame_done` with `frame_len` = 3, `err_code` = 00.
- Bad checksum: A5 02 01 02 00 → two writes, then `frame_err` with `err_code` = 10; `frame_len` unchanged.
- Bad length: A5 00, then separately A5 72 (114) → `frame_err`/01 each time; no writes.
- Timeout: A5 02 11, then idle for `TIMEOUT_CYCLES` → one write, then `frame_err`/11 exactly `TIMEOUT_CYCLES`-1 cycles after the 11 byte.
- Edge cases:
  - Noise bytes 00 FF before A5.
  - `rx_valid` on every cycle for a full frame.
  - Expected: noise ignored, all payload bytes written.
- Reset mid-frame: A5 04 01 02, then `reset` for one cycle → `busy` = 0; no further writes; the next frame A5 01 05 FA completes normally.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared constants for the UART frame writer
package uart_frame_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LEN     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CSUM    = 2'd3;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_timeout.sv
// rtl/uart_frame_timeout.sv - inter-byte timeout down-counter
// Reloads on clear; expired fires in the cycle whose edge would make the
// elapsed count reach TIMEOUT_CYCLES-1, so the caller can register the abort.
module uart_frame_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk_Rx,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 2);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_Rx) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (enable && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = enable && !clear && (cnt == W'(1));

endmodule

// File: rtl/uart_frame_writer.sv
// rtl/uart_frame_writer.sv - frame parser writing payload bytes to command memory
// Frame: sync, length, payload (stored at descending addresses), checksum.
module uart_frame_writer
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         BASE_ADDR      = 113,
  parameter int         MAX_LEN        = 113,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_Rx,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_addr,
  output logic [7:0] mem_wr_data,
  output logic       frame_done,
  output logic [7:0] frame_len,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [7:0] BASE8 = 8'(BASE_ADDR);
  localparam logic [7:0] MAX8  = 8'(MAX_LEN);

  logic [1:0] state;
  logic [7:0] len;
  logic [7:0] sum;
  logic [7:0] idx;
  logic       expired;

  uart_frame_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_Rx  (clk_Rx),
    .reset   (reset),
    .clear   (rx_valid || state == ST_IDLE),
    .enable  (state != ST_IDLE),
    .expired (expired)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk_Rx) begin
    if (reset) begin
      state       <= ST_IDLE;
      len         <= '0;
      sum         <= '0;
      idx         <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      frame_done  <= 1'b0;
      frame_len   <= '0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      mem_wr_en  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      // expired is already masked by rx_valid, so an arriving byte always wins
      if (expired) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TMO;
        state     <= ST_IDLE;
      end else if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) state <= ST_LEN;
          end
          ST_LEN: begin
            if (rx_data == 8'd0 || rx_data > MAX8) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= ST_IDLE;
            end else begin
              len   <= rx_data;
              sum   <= rx_data;
              idx   <= '0;
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= BASE8 - idx;
            mem_wr_data <= rx_data;
            sum         <= sum + rx_data;
            idx         <= idx + 8'd1;
            if (idx == len - 8'd1) state <= ST_CSUM;
          end
          default: begin
            if (8'(rx_data + sum) == 8'h00) begin
              frame_done <= 1'b1;
              frame_len  <= len;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CSUM;
            end
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_writer.sv
// tb/tb_uart_frame_writer.sv - self-checking bench for uart_frame_writer
module tb_uart_frame_writer;

  localparam int T = 20;

  logic       clk_Rx = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       mem_wr_en;
  logic [7:0] mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic       frame_done;
  logic [7:0] frame_len;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  always #5 clk_Rx = ~clk_Rx;

  uart_frame_writer #(.TIMEOUT_CYCLES(T)) dut (
    .clk_Rx      (clk_Rx),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .frame_done  (frame_done),
    .frame_len   (frame_len),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: the bytes of the frame collected so far; its size says where we are.
  logic [7:0] fbuf[$];
  int         gap = 0;
  int         cyc = 0;
  int         last_byte_cyc = 0;
  int         err_cyc = 0;
  bit         started = 0;
  logic       exp_wr_en = 0, exp_done = 0, exp_err = 0, exp_busy = 0;
  logic [7:0] exp_wr_addr = 0, exp_wr_data = 0, exp_len = 0;
  logic [1:0] exp_code = 0;

  task automatic model_byte(input logic [7:0] b);
    int n;
    int s;
    if (fbuf.size() == 0) begin
      if (b == 8'hA5) fbuf.push_back(b);
    end else if (fbuf.size() == 1) begin
      if (b == 0 || b > 113) begin
        exp_err = 1; exp_code = 2'b01; fbuf.delete();
      end else fbuf.push_back(b);
    end else begin
      n = int'(fbuf[1]);
      if (fbuf.size() - 2 < n) begin
        exp_wr_en   = 1;
        exp_wr_addr = 8'(113 - (fbuf.size() - 2));
        exp_wr_data = b;
        fbuf.push_back(b);
      end else begin
        s = int'(b);
        for (int i = 1; i < fbuf.size(); i++) s += int'(fbuf[i]);
        if (s % 256 == 0) begin
          exp_done = 1; exp_len = 8'(n);
        end else begin
          exp_err = 1; exp_code = 2'b10;
        end
        fbuf.delete();
      end
    end
  endtask

  always @(posedge clk_Rx) begin
    started = 1;
    if (rx_valid) last_byte_cyc = cyc;
    cyc++;
    if (reset) begin
      exp_wr_en = 0; exp_wr_addr = 0; exp_wr_data = 0;
      exp_done = 0; exp_err = 0; exp_len = 0; exp_code = 0;
      fbuf.delete(); gap = 0;
    end else begin
      exp_wr_en = 0; exp_done = 0; exp_err = 0;
      if (rx_valid) begin
        gap = 0;
        model_byte(rx_data);
      end else if (fbuf.size() != 0) begin
        gap++;
        if (gap == T - 2) begin
          exp_err = 1; exp_code = 2'b11; fbuf.delete();
        end
      end
    end
    exp_busy = (fbuf.size() != 0);
  end

  logic [15:0] wr_log[$];
  int done_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk_Rx) begin
    if (started) begin
      check("mem_wr_en", mem_wr_en, exp_wr_en);
      check("mem_wr_addr", mem_wr_addr, exp_wr_addr);
      check("mem_wr_data", mem_wr_data, exp_wr_data);
      check("frame_done", frame_done, exp_done);
      check("frame_err", frame_err, exp_err);
      check("frame_len", frame_len, exp_len);
      check("err_code", err_code, exp_code);
      check("busy", busy, exp_busy);
      check("done_err_exclusive", frame_done & frame_err, 0);
      if (mem_wr_en === 1'b1) wr_log.push_back({mem_wr_addr, mem_wr_data});
      if (frame_done === 1'b1) done_cnt++;
      if (frame_err === 1'b1) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  logic [7:0] stim[$];

  task automatic send(input int gap_cycles);
    foreach (stim[i]) begin
      @(negedge clk_Rx);
      rx_valid = 1'b1;
      rx_data  = stim[i];
      repeat (gap_cycles) begin
        @(negedge clk_Rx);
        rx_valid = 1'b0;
      end
    end
    @(negedge clk_Rx);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_Rx);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    done_cnt = 0;
    err_cnt = 0;
  endtask

  function automatic logic [15:0] wr_at(input int k);
    return (wr_log.size() > k) ? wr_log[k] : 16'hDEAD;
  endfunction

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk_Rx);
    reset = 1'b0;
    #1;
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_frame_len", frame_len, 0);
    check("rst_err_code", err_code, 0);
    check("rst_busy", busy, 0);

    clear_logs();
    stim = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9D};
    send(1);
    idle(3);
    check("good_nwr", wr_log.size(), 3);
    check("good_w0", wr_at(0), 16'h7110);
    check("good_w1", wr_at(1), 16'h7020);
    check("good_w2", wr_at(2), 16'h6F30);
    check("good_done", done_cnt, 1);
    check("good_len", frame_len, 3);
    check("good_code", err_code, 0);

    clear_logs();
    stim = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
    send(0);
    idle(3);
    check("csum_nwr", wr_log.size(), 2);
    check("csum_w0", wr_at(0), 16'h7101);
    check("csum_w1", wr_at(1), 16'h7002);
    check("csum_err", err_cnt, 1);
    check("csum_code", err_code, 2);
    check("csum_len_held", frame_len, 3);

    clear_logs();
    stim = '{8'hA5, 8'h00};
    send(0);
    idle(2);
    check("len0_err", err_cnt, 1);
    check("len0_code", err_code, 1);
    stim = '{8'hA5, 8'h72};
    send(0);
    idle(2);
    check("len114_err", err_cnt, 2);
    check("len_nwr", wr_log.size(), 0);

    clear_logs();
    stim = '{8'hA5, 8'h02, 8'h11};
    send(0);
    idle(T + 5);
    check("tmo_nwr", wr_log.size(), 1);
    check("tmo_w0", wr_at(0), 16'h7111);
    check("tmo_err", err_cnt, 1);
    check("tmo_code", err_code, 3);
    check("tmo_delay", err_cyc - last_byte_cyc, T - 1);

    clear_logs();
    stim = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'hAA, 8'h55, 8'hFF,
             8'hA5, 8'h02, 8'hA5, 8'h10, 8'h49};
    send(0);
    idle(3);
    check("b2b_nwr", wr_log.size(), 4);
    check("b2b_w0", wr_at(0), 16'h71AA);
    check("b2b_w1", wr_at(1), 16'h7055);
    check("b2b_w2", wr_at(2), 16'h71A5);
    check("b2b_w3", wr_at(3), 16'h7010);
    check("b2b_done", done_cnt, 2);
    check("b2b_err", err_cnt, 0);

    clear_logs();
    stim = '{8'hA5, 8'h01, 8'h07, 8'hF8};
    send(T - 3);
    idle(3);
    check("tc_byte_wins_err", err_cnt, 0);
    check("tc_byte_wins_done", done_cnt, 1);
    check("tc_w0", wr_at(0), 16'h7107);

    clear_logs();
    stim = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send(0);
    reset = 1'b1;
    @(negedge clk_Rx);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_len", frame_len, 0);
    stim = '{8'hA5, 8'h01, 8'h05, 8'hFA};
    send(0);
    idle(3);
    check("rst_mid_w_last", wr_at(wr_log.size() - 1), 16'h7105);
    check("rst_mid_done", done_cnt, 1);
    check("rst_mid_frame_len", frame_len, 1);
    check("rst_mid_err", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
